// File: rtl/data_manager_mc_if.sv
// Request/response bundle for data_manager_mc: serve and load commands in,
// read address, strobe, error and per-channel exhaustion flags out.
interface data_manager_mc_if #(
   parameter int NUM_CH = 4,
   parameter int DEPTH  = 256
);
   localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int AW   = $clog2(DEPTH);

   logic                 SERVE_REG;
   logic [CH_W-1:0]      ch_sel;
   logic                 load;
   logic [CH_W-1:0]      load_ch;
   logic [AW:0]          load_count;
   logic                 ready;
   logic [CH_W+AW-1:0]   rd_addr;
   logic                 regEn;
   logic [NUM_CH-1:0]    OutOfData;
   logic                 err;

   modport master (
      output SERVE_REG, ch_sel, load, load_ch, load_count,
      input  ready, rd_addr, regEn, OutOfData, err
   );

   modport slave (
      input  SERVE_REG, ch_sel, load, load_ch, load_count,
      output ready, rd_addr, regEn, OutOfData, err
   );
endinterface

// File: rtl/data_manager_mc.sv
// Multi-channel record server: per-channel pointer/count into a shared
// synchronous record memory, one record per accepted request.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | ready; request is evaluated, accepted or rejected with err
// S_FETCH  | rd_addr held, memory read in flight; pointer advances at exit
// S_STROBE | regEn high, downstream register captures the memory data
module data_manager_mc #(
   parameter int NUM_CH = 4,
   parameter int DEPTH  = 256,
   parameter bit WRAP   = 1'b0
) (
   input logic              clock,
   input logic              reset,
   data_manager_mc_if.slave bus
);
   localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int AW   = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_V  = DEPTH[AW:0];
   localparam logic [31:0] NUM_CH_U = NUM_CH;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_FETCH  = 2'd1,
      S_STROBE = 2'd2
   } state_t;

   state_t            state_q;
   state_t            state_d;

   logic [AW:0]       count_q [NUM_CH];
   logic [AW:0]       ptr_q   [NUM_CH];
   logic [CH_W-1:0]   cur_ch_q;
   logic [AW:0]       idx_q;
   logic [CH_W+AW-1:0] rd_addr_q;
   logic              err_q;

   logic              req_ch_ok;
   logic              load_ch_ok;
   logic              take;
   logic              collide;
   logic              accept;
   logic              reject;
   logic [AW:0]       sel_cnt;
   logic [AW:0]       sel_ptr;
   logic [AW:0]       serve_idx;
   logic [AW:0]       load_cnt;
   logic [NUM_CH-1:0] ood;

   // Request evaluation; channel numbers beyond NUM_CH are only possible
   // when NUM_CH=1, and such commands are ignored.
   always_comb begin
      req_ch_ok  = (32'(bus.ch_sel) < NUM_CH_U);
      load_ch_ok = (32'(bus.load_ch) < NUM_CH_U);
      sel_cnt    = req_ch_ok ? count_q[bus.ch_sel] : '0;
      sel_ptr    = req_ch_ok ? ptr_q[bus.ch_sel] : '0;
      take       = bus.SERVE_REG && (state_q == S_IDLE);
      collide    = bus.load && load_ch_ok && (bus.load_ch == bus.ch_sel);
      accept     = take && req_ch_ok && !collide && (sel_cnt != '0)
                   && ((sel_ptr < sel_cnt) || WRAP);
      reject     = take && !accept;
      serve_idx  = (sel_ptr < sel_cnt) ? sel_ptr : '0;
      load_cnt   = (bus.load_count > DEPTH_V) ? DEPTH_V : bus.load_count;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (accept) state_d = S_FETCH;
         S_FETCH:  state_d = S_STROBE;
         S_STROBE: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_comb begin
      bus.ready = (state_q == S_IDLE);
      bus.regEn = (state_q == S_STROBE);
   end

   // A load on the in-flight channel during FETCH takes priority over the
   // pointer advance, so the transaction completes but the channel restarts.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int c = 0; c < NUM_CH; c++) begin
            count_q[c] <= '0;
            ptr_q[c]   <= '0;
         end
         cur_ch_q  <= '0;
         idx_q     <= '0;
         rd_addr_q <= '0;
         err_q     <= 1'b0;
      end else begin
         err_q <= reject;
         if (accept) begin
            cur_ch_q  <= bus.ch_sel;
            idx_q     <= serve_idx;
            rd_addr_q <= {bus.ch_sel, serve_idx[AW-1:0]};
         end
         for (int c = 0; c < NUM_CH; c++) begin
            if (bus.load && load_ch_ok && (bus.load_ch == CH_W'(c))) begin
               count_q[c] <= load_cnt;
               ptr_q[c]   <= '0;
            end else if ((state_q == S_FETCH) && (cur_ch_q == CH_W'(c))) begin
               ptr_q[c] <= idx_q + (AW+1)'(1);
            end
         end
      end
   end

   always_comb begin
      ood = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         ood[c] = (ptr_q[c] >= count_q[c]);
      end
   end

   assign bus.OutOfData = ood;
   assign bus.rd_addr   = rd_addr_q;
   assign bus.err       = err_q;
endmodule

// File: doc/data_manager_mc.md
# data_manager_mc

Multi-channel, parametrised successor to the single-stream data manager. It keeps a per-channel read pointer and record count into a shared synchronous record memory, and serves one record per `SERVE_REG` request. Each served record produces an address, then a one-cycle `regEn` strobe that loads the downstream data register. Per-channel `OutOfData` flags mark an exhausted channel, and an optional wrap mode replays a channel from record 0.

## Interface
Parameters:
- `NUM_CH`, default 4: number of channels; must be a power of two, ≥ 1.
- `DEPTH`, default 256: records per channel; must be a power of two, ≥ 2.
- `WRAP`, default 0:
  - 1: a request to an exhausted channel rewinds it to record 0 and serves that record.
  - 0: such a request is rejected.
- Derived: `CH_W` = max(1, clog2(`NUM_CH`)); `AW` = clog2(`DEPTH`).

Ports:
- `clock`  in  1: single clock; all logic updates on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `SERVE_REG`  in  1: serve request; sampled only when `ready`=1.
- `ch_sel`  in  `CH_W`: channel for `SERVE_REG`.
- `load`  in  1: one-cycle command; sets the count of `load_ch` and rewinds its pointer.
- `load_ch`  in  `CH_W`: target channel for `load`.
- `load_count`  in  `AW`+1: number of valid records, 0..`DEPTH`.
- `ready`  out  1: FSM is idle and can accept `SERVE_REG`.
- `rd_addr`  out  `CH_W`+`AW`: registered memory address {channel, pointer}.
- `regEn`  out  1: one-cycle strobe; downstream register captures memory data.
- `OutOfData`  out  `NUM_CH`: bit c is 1 when ptr[c] ≥ count[c].
- `err`  out  1: one-cycle pulse when a request is rejected.

## Operation
- State per channel:
  - count[c], `AW`+1 bits.
  - ptr[c], `AW`+1 bits.
- FSM states: IDLE, FETCH, STROBE.
  - IDLE → FETCH when `SERVE_REG` & `ready` and the request is accepted; otherwise stay in IDLE.
  - FETCH → STROBE unconditionally (one cycle of synchronous-memory read latency).
  - STROBE → IDLE unconditionally.
- Acceptance rules:
  - count[ch]=0: always reject.
  - ptr[ch] < count[ch]: accept; serve record ptr[ch].
  - ptr[ch] ≥ count[ch] and `WRAP`=1: accept; serve record 0; ptr is treated as 0.
  - ptr[ch] ≥ count[ch] and `WRAP`=0: reject.
- On reject: `err`=1 for one cycle, FSM stays in IDLE, no state changes.
- On accept: `rd_addr` ← {ch, served index[`AW`-1:0]}. The channel number is latched for the whole transaction.
- On the FETCH→STROBE edge: ptr[ch] ← served index + 1. The pointer saturates at `DEPTH`; this cannot overflow because count ≤ `DEPTH`.
- `OutOfData` is combinational from the registered ptr/count, so it changes in the same cycle `regEn` is high.
- `load`:
  - count[load_ch] ← min(`load_count`, `DEPTH`).
  - ptr[load_ch] ← 0.
  - Accepted in any FSM state.
- Simultaneous events:
  - `load` and an accepted `SERVE_REG` on the same channel in the same cycle: load wins, the request is rejected with `err`.
  - `load` targeting the in-flight channel while in FETCH: the transaction still issues `regEn`, but its pointer increment is discarded.
  - `load` on a different channel: fully independent of the transaction.
- Reset:
  - Synchronous; overrides everything, including a transaction in progress.
  - All counts and pointers ← 0, FSM ← IDLE, `rd_addr` ← 0, `regEn` ← 0, `err` ← 0.
  - Hence `OutOfData` = all ones and `ready`=1 after the reset edge.
  - A transaction in progress does not produce `regEn`.

## Timing
- Request sampled at edge E0:
  - `rd_addr` valid and `ready`=0 from E0.
  - Memory data available after E1.
  - `regEn`=1 from E1 to E2.
  - `ready`=1 again from E2.
- Request-to-strobe latency: 2 cycles. Maximum throughput: one record per 3 cycles.
- `err` is asserted from the sampling edge for exactly one cycle.
- `regEn` never asserts in two consecutive cycles.
- `ready` = (state == IDLE), decoded from registered state only.

## Test plan
- Reset, then check outputs: `OutOfData`=4'hF, `ready`=1, `regEn`=0, `rd_addr`=0. Then serve ch0 → `err` pulse, no `regEn`.
- Load ch2 with `load_count`=3, then serve ch2 four times (`WRAP`=0):
  - Three `regEn` pulses with `rd_addr` = {2,0}, {2,1}, {2,2}, each 2 cycles after its request.
  - `OutOfData`[2] rises with the third `regEn`.
  - The fourth request gives an `err` pulse.
- `WRAP`=1, load ch1 with 2, serve five times → addresses {1,0}, {1,1}, {1,0}, {1,1}, {1,0}; no `err`.
- Load ch3 with `DEPTH`, serve `DEPTH` times → addresses 0..`DEPTH`-1 with no aliasing; `OutOfData`[3]=1 only after the last strobe.
- Same-cycle `load` ch0=5 and `SERVE_REG` ch0 → `err`, ptr0=0. Then `load` ch0 during FETCH of a ch0 serve → `regEn` still fires, and the next serve uses `rd_addr` {0,0}.
- Assert `reset` in the FETCH cycle → no `regEn`, `OutOfData` all ones, `ready`=1 on the next cycle.
